// File: rtl/bip2_fetch_ctrl.sv
// rtl/bip2_fetch_ctrl.sv - BIP-2 fetch/sequencing controller: PC control, IR latch, branch resolution, halt/resume
module bip2_fetch_ctrl #(
    parameter int                ADDR_W       = 11,
    parameter int                INSTR_W      = 16,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic [ADDR_W-1:0]  pc_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic               zero_i,
    input  logic               neg_i,
    input  logic               run_i,
    output logic               pc_en_o,
    output logic [ADDR_W-1:0]  pc_next_o,
    output logic [INSTR_W-1:0] ir_o,
    output logic               exec_o,
    output logic               halt_o,
    output logic               illegal_o
);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_FETCH,
        ST_EXEC,
        ST_HALT
    } state_t;

    localparam logic [4:0] OP_HLT = 5'd0;
    localparam logic [4:0] OP_STO = 5'd1;
    localparam logic [4:0] OP_LD  = 5'd2;
    localparam logic [4:0] OP_LDI = 5'd3;
    localparam logic [4:0] OP_ADD = 5'd4;
    localparam logic [4:0] OP_ADDI = 5'd5;
    localparam logic [4:0] OP_SUB = 5'd6;
    localparam logic [4:0] OP_SUBI = 5'd7;
    localparam logic [4:0] OP_BEQ = 5'd8;
    localparam logic [4:0] OP_BNE = 5'd9;
    localparam logic [4:0] OP_BGT = 5'd10;
    localparam logic [4:0] OP_BGE = 5'd11;
    localparam logic [4:0] OP_BLT = 5'd12;
    localparam logic [4:0] OP_BLE = 5'd13;
    localparam logic [4:0] OP_JMP = 5'd14;

    state_t              state_q, state_d;
    logic [INSTR_W-1:0]  ir_q, ir_d;
    logic                illegal_q, illegal_d;

    logic [4:0]          opcode;
    logic [ADDR_W-1:0]   operand;
    logic [ADDR_W-1:0]   pc_inc;
    logic                taken;

    assign opcode  = ir_q[INSTR_W-1 -: 5];
    assign operand = ir_q[ADDR_W-1:0];
    // Sequential PC wraps modulo 2^ADDR_W with no carry out
    assign pc_inc  = pc_i + ADDR_W'(1);

    assign ir_o      = ir_q;
    assign illegal_o = illegal_q;

    // State, instruction register and sticky illegal flag; async reset returns to INIT
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= ST_INIT;
            ir_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            illegal_q <= illegal_d;
        end
    end

    // Next state and PC control; in FETCH/HALT pc_next_o defaults to pc_i so a PC ignoring enable holds
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        illegal_d = illegal_q;
        pc_en_o   = 1'b0;
        pc_next_o = pc_i;
        exec_o    = 1'b0;
        halt_o    = 1'b0;
        taken     = 1'b0;

        case (state_q)
            ST_INIT: begin
                pc_en_o   = 1'b1;
                pc_next_o = RESET_VECTOR;
                state_d   = ST_FETCH;
            end

            ST_FETCH: begin
                ir_d    = instr_i;
                state_d = ST_EXEC;
            end

            ST_EXEC: begin
                exec_o    = 1'b1;
                pc_en_o   = 1'b1;
                pc_next_o = pc_inc;
                state_d   = ST_FETCH;
                case (opcode)
                    OP_HLT: begin
                        pc_en_o   = 1'b0;
                        pc_next_o = pc_i;
                        state_d   = ST_HALT;
                    end
                    OP_STO, OP_LD, OP_LDI, OP_ADD,
                    OP_ADDI, OP_SUB, OP_SUBI: begin
                        taken = 1'b0;
                    end
                    OP_BEQ:  taken = zero_i;
                    OP_BNE:  taken = !zero_i;
                    OP_BGT:  taken = !zero_i && !neg_i;
                    OP_BGE:  taken = !neg_i;
                    OP_BLT:  taken = neg_i;
                    OP_BLE:  taken = neg_i || zero_i;
                    OP_JMP:  taken = 1'b1;
                    // Undefined opcodes behave as NOP but are flagged until reset
                    default: illegal_d = 1'b1;
                endcase
                if (taken) begin
                    pc_next_o = operand;
                end
            end

            ST_HALT: begin
                halt_o = 1'b1;
                // Resume skips past the HLT so it is not executed again
                if (run_i) begin
                    pc_en_o   = 1'b1;
                    pc_next_o = pc_inc;
                    state_d   = ST_FETCH;
                end
            end

            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

endmodule

// File: tb/tb_bip2_fetch_ctrl.sv
// tb/tb_bip2_fetch_ctrl.sv - scoreboard testbench for bip2_fetch_ctrl
module tb_bip2_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic [10:0] pc_q = 11'h555;
    logic [15:0] mem  [0:2047];
    logic        zmem [0:2047];
    logic        nmem [0:2047];

    logic [15:0] instr;
    logic        zero, neg;
    logic        pc_en, exec, halt, illegal;
    logic [10:0] pc_next;
    logic [15:0] ir;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [10:0] pc;
        logic [15:0] ir;
        logic        en;
        logic [10:0] nxt;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    assign instr = mem[pc_q];
    assign zero  = zmem[pc_q];
    assign neg   = nmem[pc_q];

    bip2_fetch_ctrl #(
        .ADDR_W      (11),
        .INSTR_W     (16),
        .RESET_VECTOR(11'd0)
    ) dut (
        .clock_i  (clk),
        .reset_i  (rst),
        .pc_i     (pc_q),
        .instr_i  (instr),
        .zero_i   (zero),
        .neg_i    (neg),
        .run_i    (run),
        .pc_en_o  (pc_en),
        .pc_next_o(pc_next),
        .ir_o     (ir),
        .exec_o   (exec),
        .halt_o   (halt),
        .illegal_o(illegal)
    );

    always #5 clk = ~clk;

    // PC register model: no reset, loads on enable
    always @(posedge clk) begin
        if (pc_en) pc_q <= pc_next;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic expect_exec(input logic [10:0] a, input logic [15:0] w, input logic en,
                               input logic [10:0] nxt, input logic ill);
        sb.push_back('{pc: a, ir: w, en: en, nxt: nxt, ill: ill});
    endtask

    task automatic prog(input logic [10:0] a, input logic [15:0] w, input logic z, input logic n,
                        input logic en, input logic [10:0] nxt, input logic ill);
        mem[a]  = w;
        zmem[a] = z;
        nmem[a] = n;
        expect_exec(a, w, en, nxt, ill);
    endtask

    task automatic wait_halt(input int budget, input string name);
        bit seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(posedge clk);
            #1;
            if (halt) seen = 1'b1;
        end
        chk(name, 32'(seen), 32'd1);
    endtask

    // Monitor: every EXEC cycle pops one expected instruction and compares
    always @(negedge clk) begin
        if (!rst && exec) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL exec_unexpected actual pc=%0h required no exec", pc_q);
            end else begin
                e = sb.pop_front();
                chk("exec_pc", 32'(pc_q), 32'(e.pc));
                chk("exec_ir", 32'(ir), 32'(e.ir));
                chk("exec_pc_en", 32'(pc_en), 32'(e.en));
                if (e.en) chk("exec_pc_next", 32'(pc_next), 32'(e.nxt));
                chk("exec_illegal", 32'(illegal), 32'(e.ill));
                chk("exec_halt", 32'(halt), 32'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        bit found;
        for (int i = 0; i < 2048; i++) begin
            mem[i]  = 16'h0000;
            zmem[i] = 1'b0;
            nmem[i] = 1'b0;
        end

        // Phase 1 program, in execution order: (addr, word, Z, N, pc_en, pc_next, illegal during EXEC)
        prog(11'h000, 16'h2801, 0, 0, 1, 11'h001, 0);  // ADDI
        prog(11'h001, 16'h0800, 0, 0, 1, 11'h002, 0);  // STO
        prog(11'h002, 16'h1000, 0, 0, 1, 11'h003, 0);  // LD
        prog(11'h003, 16'h3000, 0, 0, 1, 11'h004, 0);  // SUB
        prog(11'h004, 16'h3800, 0, 0, 1, 11'h005, 0);  // SUBI
        prog(11'h005, 16'h1807, 0, 0, 1, 11'h006, 0);  // LDI
        prog(11'h006, 16'h73A0, 0, 0, 1, 11'h3A0, 0);  // JMP 0x3A0
        prog(11'h3A0, 16'h4010, 0, 0, 1, 11'h3A1, 0);  // BEQ Z=0 not taken
        prog(11'h3A1, 16'h4010, 1, 0, 1, 11'h010, 0);  // BEQ Z=1 taken
        prog(11'h010, 16'h4820, 1, 0, 1, 11'h011, 0);  // BNE Z=1 not taken
        prog(11'h011, 16'h4830, 0, 0, 1, 11'h030, 0);  // BNE Z=0 taken
        prog(11'h030, 16'h5040, 0, 1, 1, 11'h031, 0);  // BGT N=1 not taken
        prog(11'h031, 16'h5040, 0, 0, 1, 11'h040, 0);  // BGT Z=0 N=0 taken
        prog(11'h040, 16'h5850, 0, 1, 1, 11'h041, 0);  // BGE N=1 not taken
        prog(11'h041, 16'h5850, 1, 0, 1, 11'h050, 0);  // BGE N=0 taken
        prog(11'h050, 16'h6060, 0, 0, 1, 11'h051, 0);  // BLT N=0 not taken
        prog(11'h051, 16'h6060, 0, 1, 1, 11'h060, 0);  // BLT N=1 taken
        prog(11'h060, 16'h6870, 0, 0, 1, 11'h061, 0);  // BLE N=0 Z=0 not taken
        prog(11'h061, 16'h6870, 0, 1, 1, 11'h070, 0);  // BLE N=1 taken
        prog(11'h070, 16'h6820, 1, 0, 1, 11'h020, 0);  // BLE Z=1 taken
        prog(11'h020, 16'h0000, 0, 0, 0, 11'h000, 0);  // HLT
        prog(11'h021, 16'hF800, 0, 0, 1, 11'h022, 0);  // opcode 11111
        prog(11'h022, 16'h0000, 0, 0, 0, 11'h000, 1);  // HLT
        prog(11'h023, 16'h2801, 0, 0, 1, 11'h024, 1);  // ADDI
        prog(11'h024, 16'h7800, 0, 0, 1, 11'h025, 1);  // opcode 01111
        prog(11'h025, 16'h0000, 0, 0, 0, 11'h000, 1);  // HLT

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ir", 32'(ir), 32'h0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_exec", 32'(exec), 32'd0);
        chk("rst_halt", 32'(halt), 32'd0);

        @(negedge clk);
        rst = 1'b0;
        chk("init_pc_en", 32'(pc_en), 32'd1);
        chk("init_pc_next", 32'(pc_next), 32'h000);
        @(posedge clk);
        #1;
        chk("fetch0_pc", 32'(pc_q), 32'h000);
        chk("fetch0_pc_en", 32'(pc_en), 32'd0);
        chk("fetch0_pc_next", 32'(pc_next), 32'h000);
        chk("fetch0_exec", 32'(exec), 32'd0);

        wait_halt(200, "halt_020_reached");
        for (int i = 0; i < 10; i++) begin
            chk("halt_hold_flag", 32'(halt), 32'd1);
            chk("halt_hold_pc_en", 32'(pc_en), 32'd0);
            chk("halt_hold_pc", 32'(pc_q), 32'h020);
            chk("halt_hold_ir", 32'(ir), 32'h0000);
            @(posedge clk);
            #1;
        end
        run = 1'b1;
        #1;
        chk("resume_pc_en", 32'(pc_en), 32'd1);
        chk("resume_pc_next", 32'(pc_next), 32'h021);
        @(posedge clk);
        #1;
        run = 1'b0;
        chk("resume_fetch_halt", 32'(halt), 32'd0);
        chk("resume_fetch_exec", 32'(exec), 32'd0);
        chk("resume_fetch_pc", 32'(pc_q), 32'h021);

        wait_halt(20, "halt_022_reached");
        chk("halt_022_pc", 32'(pc_q), 32'h022);
        chk("halt_022_illegal", 32'(illegal), 32'd1);
        run = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("run_held_no_halt", 32'(halt), 32'd0);
        end
        run = 1'b0;
        wait_halt(20, "halt_025_reached");
        chk("halt_025_pc", 32'(pc_q), 32'h025);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("halt_025_stays", 32'(halt), 32'd1);
            chk("halt_025_pc_en", 32'(pc_en), 32'd0);
        end
        chk("sb_drained_phase1", 32'(sb.size()), 32'd0);

        // Phase 2: wraparound and reset mid-EXEC with illegal set
        rst = 1'b1;
        #1;
        chk("rst2_illegal", 32'(illegal), 32'd0);
        chk("rst2_ir", 32'(ir), 32'h0);
        chk("rst2_halt", 32'(halt), 32'd0);
        prog(11'h000, 16'hFFFF, 0, 0, 1, 11'h001, 0);  // opcode 11111
        prog(11'h001, 16'h77FF, 0, 0, 1, 11'h7FF, 1);  // JMP 0x7FF
        mem[11'h7FF] = 16'h2000;                        // ADD
        @(negedge clk);
        rst = 1'b0;

        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(posedge clk);
            #1;
            if (exec && pc_q == 11'h7FF) found = 1'b1;
        end
        chk("exec_7ff_reached", 32'(found), 32'd1);
        chk("wrap_pc_en", 32'(pc_en), 32'd1);
        chk("wrap_pc_next", 32'(pc_next), 32'h000);
        chk("wrap_ir", 32'(ir), 32'h2000);
        chk("wrap_illegal", 32'(illegal), 32'd1);
        rst = 1'b1;
        #1;
        chk("midexec_rst_exec", 32'(exec), 32'd0);
        chk("midexec_rst_illegal", 32'(illegal), 32'd0);
        chk("midexec_rst_ir", 32'(ir), 32'h0);
        chk("midexec_rst_pc_en", 32'(pc_en), 32'd1);
        chk("midexec_rst_pc_next", 32'(pc_next), 32'h000);
        expect_exec(11'h000, 16'hFFFF, 1, 11'h001, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("restart_fetch_pc", 32'(pc_q), 32'h000);
        chk("restart_fetch_exec", 32'(exec), 32'd0);
        chk("restart_fetch_pc_en", 32'(pc_en), 32'd0);
        @(posedge clk);
        #1;
        chk("restart_exec", 32'(exec), 32'd1);
        #5;
        rst = 1'b1;
        #1;
        chk("sb_drained_phase2", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bip2_fetch_ctrl.md
# bip2_fetch_ctrl

Fetch/sequencing controller for the BIP-2 core; directly upstream of the PC register. It drives the PC's load enable and next-address input, latches the instruction word returned by program memory, and resolves jumps and conditional branches against the ALU status flags. Every instruction takes a fixed two cycles: FETCH then EXEC. The block also owns halt/resume and the post-reset PC initialisation, since the PC register itself has no reset.

## Interface
- RESET_VECTOR, 11'd0, address loaded into PC after reset
- ADDR_W, 11, PC/operand width
- INSTR_W, 16, instruction width (opcode = [15:11], operand = [10:0])

Ports:
- clock_i  in  1  single clock; all state changes on rising edge
- reset_i  in  1  asynchronous, active-high reset
- pc_i  in  ADDR_W  current PC (PC register output; also program-memory address)
- instr_i  in  INSTR_W  program-memory read data, valid one clock after pc_i is stable
- zero_i  in  1  status Z from ALU status register
- neg_i  in  1  status N from ALU status register
- run_i  in  1  resume request; only honoured in HALT
- pc_en_o  out  1  PC load enable (PC enable input)
- pc_next_o  out  ADDR_W  next PC value (PC mux input)
- ir_o  out  INSTR_W  instruction register, to decoder/datapath
- exec_o  out  1  high during EXEC; datapath commits results only when high
- halt_o  out  1  high in HALT
- illegal_o  out  1  sticky: undefined opcode executed

## Operation
- States: INIT, FETCH, EXEC, HALT. Reset (async) → INIT; ir_o=0, illegal_o=0.
- INIT (1 cycle): pc_en_o=1, pc_next_o=RESET_VECTOR; → FETCH.
- FETCH: pc_en_o=0, pc_next_o=pc_i; at the closing edge ir_o←instr_i; → EXEC.
- EXEC: pc_en_o=1 except for HLT; exec_o=1; target is computed from ir_o and flags; → FETCH.
  - 00000 HLT: pc_en_o=0; → HALT.
  - 00001–00111 (STO, LD, LDI, ADD, ADDI, SUB, SUBI): pc_next_o=pc_i+1.
  - 01000 BEQ taken if Z; 01001 BNE if !Z; 01010 BGT if !Z&!N; 01011 BGE if !N; 01100 BLT if N; 01101 BLE if N|Z; 01110 JMP always.
    - Taken: pc_next_o=ir_o[10:0]; else pc_next_o=pc_i+1.
  - 01111–11111: treated as NOP (pc_i+1); illegal_o←1 at the closing edge, held until reset.
- HALT: halt_o=1; ir_o held.
  - run_i=0: pc_en_o=0; stay in HALT.
  - run_i=1: pc_en_o=1, pc_next_o=pc_i+1; → FETCH, so the HLT instruction is not re-executed.
- Arithmetic: pc_i+1 is modulo 2^ADDR_W; 2047+1 → 0, with no flag.
- Flags are sampled combinationally during EXEC. They reflect the last committed instruction; the datapath updates status only at the EXEC closing edge.

## Timing
- pc_en_o, pc_next_o, exec_o, halt_o: combinational from state, ir_o, pc_i, flags, run_i.
- ir_o, illegal_o, state: registered.
- Throughput: 1 instruction per 2 cycles. Branch penalty is zero: the target loads at the EXEC edge and is fetched in the next FETCH.
- After reset deassert: edge 1 loads RESET_VECTOR (INIT); edge 2 latches the first instruction; edge 3 completes its EXEC.
- In FETCH, pc_next_o=pc_i, so a PC that ignores enable still holds.
- Reset during FETCH or EXEC: immediate return to INIT with outputs at reset values. No partial IR update; illegal_o is cleared.
- run_i is ignored outside HALT. run_i held high in HALT resumes exactly once, because the state leaves HALT.

## Test plan
- Reset with RESET_VECTOR=0 → INIT 1 cycle (pc_en_o=1, pc_next_o=0) → FETCH/EXEC alternation; ADDI at 0 → PC=1 after EXEC.
- LDI at 5 → pc_next_o=6. JMP 0x3A0 at 6 → PC=0x3A0 after EXEC, ir_o=0x73A0.
- BEQ 0x010 with Z=0 → PC+1; with Z=1 → 0x010. BLE with N=0,Z=0 → not taken; with N=1 → taken. Cover all six branch opcodes.
- ADD at pc_i=2047 → pc_next_o=0.
- HLT at 0x020 → halt_o=1, pc_en_o=0 for 10 cycles with run_i=0. Pulse run_i → PC=0x021, next FETCH. run_i held high 5 cycles → only one resume.
- Opcode 11111 → illegal_o=1, PC advances by 1. Assert reset_i mid-EXEC → illegal_o=0, ir_o=0, state INIT within the same cycle.
